// File: rtl/uart_frame_ctrl_pkg.sv
// rtl/uart_frame_ctrl_pkg.sv - shared FSM encoding, error codes and sync marker for the frame controller
package uart_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h74;

endpackage

// File: rtl/uart_frame_ctrl_link_watchdog.sv
// rtl/uart_frame_ctrl_link_watchdog.sv - saturating link watchdog, kicked by each committed frame
module link_watchdog #(
  parameter int TIMEOUT_CYCLES = 1200000,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick_i,
  output logic ok_o
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d;

  // Counter starts expired so the link reads down until the first good frame.
  always_comb begin
    cnt_d = cnt_q;
    if (kick_i) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
    ok_d = (cnt_q < LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LIMIT;
      ok_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ok_q  <= ok_d;
    end
  end

  assign ok_o = ok_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - SYNC/LEN/payload/CSUM frame sequencer with shadow buffer and commit register
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int         MAX_BYTES      = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1200000,
  localparam int        LW             = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   rx_eop,
  output logic [MAX_BYTES*8-1:0] rx_frame,
  output logic [LW-1:0]          frame_len,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic                   link_ok
);

  localparam int         IW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  state_e                      state_q, state_d;
  logic [MAX_BYTES-1:0][7:0]   shadow_q, shadow_d;
  logic [MAX_BYTES-1:0][7:0]   frame_q, frame_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [LW-1:0]               len_q, len_d;
  logic [LW-1:0]               frame_len_q, frame_len_d;
  logic [7:0]                  acc_q, acc_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;
  logic [1:0]                  err_code_q, err_code_d;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    len_d        = len_q;
    frame_len_d  = frame_len_q;
    acc_d        = acc_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    // A byte strobe always wins over a coincident end-of-packet.
    if (rx_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d    = rx_data[LW-1:0];
            acc_d    = rx_data;
            idx_d    = '0;
            shadow_d = '0;
            state_d  = ST_DATA;
          end
        end
        ST_DATA: begin
          shadow_d[idx_q] = rx_data;
          acc_d           = acc_q ^ rx_data;
          idx_d           = idx_q + IW'(1);
          if (LW'(idx_q) == len_q - LW'(1)) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data == acc_q) begin
            frame_d     = shadow_q;
            frame_len_d = len_q;
            valid_d     = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (rx_eop && state_q != ST_IDLE) begin
      err_d      = 1'b1;
      err_code_d = ERR_TRUNC;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      frame_len_q <= '0;
      acc_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      acc_q       <= acc_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_watchdog (
    .clk_i (clk),
    .rst_i (rst),
    .kick_i(valid_d),
    .ok_o  (link_ok)
  );

  assign rx_frame    = frame_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - scoreboard bench for uart_frame_ctrl with directed frame vectors
module tb_uart_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_ready = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_eop = 1'b0;
  logic [127:0] rx_frame;
  logic [4:0]   frame_len;
  logic         frame_valid;
  logic         frame_err;
  logic [1:0]   err_code;
  logic         link_ok;

  uart_frame_ctrl #(
    .MAX_BYTES(16),
    .SYNC_BYTE(8'h74),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_eop     (rx_eop),
    .rx_frame   (rx_frame),
    .frame_len  (frame_len),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .link_ok    (link_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_valid;
    logic [1:0]   code;
    logic [127:0] frame;
    logic [4:0]   len;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [127:0] m_frame = '0;
  logic [4:0]   m_len = '0;
  logic [1:0]   m_code = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after the deciding byte was sampled; cyc is that edge.
  task automatic expect_ok(input logic [127:0] f, input logic [4:0] l);
    exp_t e;
    m_frame = f;
    m_len   = l;
    e.is_valid = 1'b1; e.code = m_code; e.frame = f; e.len = l; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] c);
    exp_t e;
    m_code = c;
    e.is_valid = 1'b0; e.code = c; e.frame = m_frame; e.len = m_len; e.cyc = cyc;
    sb.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=%0d, expected no event",
                 frame_valid, frame_err, err_code);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", {126'd0, frame_valid, frame_err},
            {126'd0, mon_e.is_valid, ~mon_e.is_valid});
        chk("err_code", 128'(err_code), 128'(mon_e.code));
        chk("rx_frame", rx_frame, mon_e.frame);
        chk("frame_len", 128'(frame_len), 128'(mon_e.len));
        chk("latency_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  task automatic strobe(input logic [7:0] b, input logic eop);
    rx_ready = 1'b1;
    rx_data  = b;
    rx_eop   = eop;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_eop   = 1'b0;
  endtask

  task automatic send_seq(input logic [255:0] s, input int n, input logic eop_last);
    for (int i = 0; i < n; i++) begin
      strobe(s[8*(n-1-i) +: 8], (i == n - 1) ? eop_last : 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic eop_pulse();
    rx_eop = 1'b1;
    @(posedge clk); #1;
    rx_eop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  logic [127:0] big;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rx_frame", rx_frame, 128'd0);
    chk("reset_frame_len", 128'(frame_len), 128'd0);
    chk("reset_err_code", 128'(err_code), 128'd0);
    chk("reset_link_ok", 128'(link_ok), 128'd0);
    chk("reset_pulses", 128'({frame_valid, frame_err}), 128'd0);

    // Good frame, 3^11^22^33 = 03
    send_seq(256'({8'h74, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), 6, 1'b0);
    expect_ok(128'h332211, 5'd3);
    idle(1);
    chk("link_ok_after_good", 128'(link_ok), 128'd1);
    idle(2);

    // Bad checksum: 02^AA^55 = FD, not 00
    send_seq(256'({8'h74, 8'h02, 8'hAA, 8'h55, 8'h00}), 5, 1'b0);
    expect_err(2'd2);
    idle(2);

    // Bad lengths 0 and 17, then a fresh frame 01^A5 = A4
    send_seq(256'({8'h74, 8'h00}), 2, 1'b0);
    expect_err(2'd1);
    send_seq(256'({8'h74, 8'h11}), 2, 1'b0);
    expect_err(2'd1);
    send_seq(256'({8'h74, 8'h01, 8'hA5, 8'hA4}), 4, 1'b0);
    expect_ok(128'hA5, 5'd1);
    idle(2);

    // Truncation, then eop in IDLE (no effect)
    send_seq(256'({8'h74, 8'h04, 8'h01, 8'h02}), 4, 1'b0);
    eop_pulse();
    expect_err(2'd3);
    idle(1);
    eop_pulse();
    idle(2);

    // eop coincident with the final byte: 02^10^20 = 32
    send_seq(256'({8'h74, 8'h02, 8'h10, 8'h20, 8'h32}), 5, 1'b1);
    expect_ok(128'h2010, 5'd2);
    idle(2);

    // SYNC value inside payload: 02^74^74 = 02
    send_seq(256'({8'h74, 8'h02, 8'h74, 8'h74, 8'h02}), 5, 1'b0);
    expect_ok(128'h7474, 5'd2);

    // Max length 16, payload 01..10; csum = 10 ^ (01^..^10) = 10 ^ 10 = 00
    strobe(8'h74, 1'b0);
    strobe(8'h10, 1'b0);
    big = '0;
    for (int i = 0; i < 16; i++) begin
      strobe(8'(i + 1), 1'b0);
      big[8*i +: 8] = 8'(i + 1);
    end
    strobe(8'h00, 1'b0);
    expect_ok(big, 5'd16);

    // Back-to-back with noise: 00 FF dropped, then 01^5A = 5B
    send_seq(256'({8'h00, 8'hFF, 8'h74, 8'h01, 8'h5A, 8'h5B}), 6, 1'b0);
    expect_ok(128'h5A, 5'd1);

    // Watchdog: high through 100 cycles after kick, low on the 101st
    idle(1);
    chk("wd_first_cycle", 128'(link_ok), 128'd1);
    idle(99);
    chk("wd_last_ok_cycle", 128'(link_ok), 128'd1);
    idle(1);
    chk("wd_expired", 128'(link_ok), 128'd0);
    idle(3);

    send_seq(256'({8'h74, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}), 6, 1'b0);
    expect_ok(128'h332211, 5'd3);
    idle(1);
    chk("wd_restored", 128'(link_ok), 128'd1);

    // Reset mid-frame: no frame_err, link drops, outputs cleared
    send_seq(256'({8'h74, 8'h03, 8'h11}), 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_frame = '0; m_len = '0; m_code = 2'd0;
    chk("rst_mid_link_ok", 128'(link_ok), 128'd0);
    chk("rst_mid_rx_frame", rx_frame, 128'd0);
    chk("rst_mid_err_code", 128'(err_code), 128'd0);
    idle(2);
    send_seq(256'({8'h74, 8'h01, 8'h5A, 8'h5B}), 4, 1'b0);
    expect_ok(128'h5A, 5'd1);

    idle(5);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
